// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths and FSM encoding for the neural-net datapath
package nn_pkg;

  localparam int ACT_W    = 10;
  localparam int WGT_W    = 8;
  localparam int FRAC_W   = 7;
  localparam int ACC_W    = 21;
  localparam int N_HIDDEN = 4;
  localparam int IDX_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_FIN  = 2'd2
  } nn_state_e;

endpackage

// File: rtl/nn_mac_unit.sv
// rtl/nn_mac_unit.sv - combinational 10x8 unsigned multiply plus 21-bit accumulate
module nn_mac_unit
  import nn_pkg::*;
(
  input  logic [ACT_W-1:0] h_i,
  input  logic [WGT_W-1:0] w_i,
  input  logic [ACC_W-1:0] acc_i,
  output logic [ACC_W-1:0] acc_o
);

  localparam int PROD_W = ACT_W + WGT_W;

  logic [PROD_W-1:0] prod;

  // Q3.7 x Q1.7 gives an 18-bit Q4.14 product, widened onto the Q7.14 accumulator
  assign prod  = {{WGT_W{1'b0}}, h_i} * {{ACT_W{1'b0}}, w_i};
  assign acc_o = acc_i + {{(ACC_W - PROD_W){1'b0}}, prod};

endmodule

// File: rtl/output_neuron_mac.sv
// rtl/output_neuron_mac.sv - sequential 4-tap MAC output neuron with start/busy/done handshake
// OUTPUT_NEURON_SAT_EN selects saturating output formatting (default: modular wrap).
module output_neuron_mac
  import nn_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic [ACT_W-1:0] h0_i,
  input  logic [ACT_W-1:0] h1_i,
  input  logic [ACT_W-1:0] h2_i,
  input  logic [ACT_W-1:0] h3_i,
  input  logic [WGT_W-1:0] w0_i,
  input  logic [WGT_W-1:0] w1_i,
  input  logic [WGT_W-1:0] w2_i,
  input  logic [WGT_W-1:0] w3_i,
  input  logic [ACT_W-1:0] bias_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ACT_W-1:0] result_o
);

  localparam logic [1:0]       IDLE     = ST_IDLE;
  localparam logic [1:0]       MAC      = ST_MAC;
  localparam logic [1:0]       FIN      = ST_FIN;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_HIDDEN - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACT_W-1:0] h_q [N_HIDDEN];
  logic [WGT_W-1:0] w_q [N_HIDDEN];
  logic [ACT_W-1:0] h_sel;
  logic [WGT_W-1:0] w_sel;
  logic [ACT_W-1:0] result_fmt;

  assign busy_o = (state != IDLE);
  assign h_sel  = h_q[idx];
  assign w_sel  = w_q[idx];

  nn_mac_unit u_mac (
    .h_i   (h_sel),
    .w_i   (w_sel),
    .acc_i (acc),
    .acc_o (acc_sum)
  );

`ifdef OUTPUT_NEURON_SAT_EN
  logic [ACT_W+3:0] acc_shr;

  assign acc_shr    = (ACT_W + 4)'(acc >> FRAC_W);
  assign result_fmt = (acc_shr > (ACT_W + 4)'({ACT_W{1'b1}})) ? {ACT_W{1'b1}} : acc_shr[ACT_W-1:0];
`else
  assign result_fmt = ACT_W'(acc >> FRAC_W);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
      for (int i = 0; i < N_HIDDEN; i++) begin
        h_q[i] <= '0;
        w_q[i] <= '0;
      end
    end else if (en_i) begin
      // done_o only survives an enabled edge that passes through FIN
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            h_q[0] <= h0_i;
            h_q[1] <= h1_i;
            h_q[2] <= h2_i;
            h_q[3] <= h3_i;
            w_q[0] <= w0_i;
            w_q[1] <= w1_i;
            w_q[2] <= w2_i;
            w_q[3] <= w3_i;
            acc    <= {{(ACC_W - ACT_W - FRAC_W){1'b0}}, bias_i, {FRAC_W{1'b0}}};
            idx    <= '0;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc_sum;
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) state <= FIN;
        end
        FIN: begin
          result_o <= result_fmt;
          done_o   <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
